// File: rtl/pellet_plotter.sv
// Rasterizes a 5x5 sprite bitmap into one pixel write per clock for the VGA plot port.
// Cells are walked in raster order; clipped or transparent cells still take their cycle.
module pellet_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [24:0]         shape,
  input  logic [X_W-1:0]      x_base,
  input  logic [Y_W-1:0]      y_base,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                transparent,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

  state_t state, state_next;

  logic [4:0]          idx;
  logic [2:0]          row, col;
  logic [24:0]         shape_q;
  logic [X_W-1:0]      x_base_q;
  logic [Y_W-1:0]      y_base_q;
  logic [COLOUR_W-1:0] fg_q, bg_q;
  logic                transparent_q;

  logic                accept, last_cell_shown, load_pixel;
  logic                src_bit, src_transparent;
  logic [X_W-1:0]      src_x;
  logic [Y_W-1:0]      src_y;
  logic [COLOUR_W-1:0] src_fg, src_bg;
  logic [2:0]          cell_row, cell_col;
  logic [X_W:0]        x_sum;
  logic [Y_W:0]        y_sum;
  logic                pix_plot;

  assign accept          = start && (state != DRAW);
  assign last_cell_shown = (state == DRAW) && (idx == 5'd25);
  assign load_pixel      = accept || ((state == DRAW) && !last_cell_shown);
  assign busy            = (state == DRAW);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRAW;
      DRAW:    if (idx == 5'd25) state_next = DONE;
      DONE:    state_next = start ? DRAW : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cell 0 is built straight from the ports on the accept edge, later cells from the latched copy.
  always_comb begin
    src_bit         = accept ? shape[24]   : shape_q[24];
    src_x           = accept ? x_base      : x_base_q;
    src_y           = accept ? y_base      : y_base_q;
    src_fg          = accept ? fg_colour   : fg_q;
    src_bg          = accept ? bg_colour   : bg_q;
    src_transparent = accept ? transparent : transparent_q;
    cell_row        = accept ? 3'd0 : row;
    cell_col        = accept ? 3'd0 : col;
    // Sums are one bit wider than the ports so an overflowing base clips instead of wrapping.
    x_sum           = {1'b0, src_x} + (X_W+1)'(cell_col);
    y_sum           = {1'b0, src_y} + (Y_W+1)'(cell_row);
    pix_plot        = (src_bit || !src_transparent) && (x_sum < X_LIM) && (y_sum < Y_LIM);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= 5'd0;
      row           <= 3'd0;
      col           <= 3'd0;
      shape_q       <= '0;
      x_base_q      <= '0;
      y_base_q      <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      transparent_q <= 1'b0;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= state_next;
      done  <= last_cell_shown;

      if (load_pixel) begin
        x      <= x_sum[X_W-1:0];
        y      <= y_sum[Y_W-1:0];
        colour <= src_bit ? src_fg : src_bg;
        plot   <= pix_plot;
      end else begin
        plot   <= 1'b0;
      end

      if (accept) begin
        shape_q       <= {shape[23:0], 1'b0};
        x_base_q      <= x_base;
        y_base_q      <= y_base;
        fg_q          <= fg_colour;
        bg_q          <= bg_colour;
        transparent_q <= transparent;
        idx           <= 5'd1;
        row           <= 3'd0;
        col           <= 3'd1;
      end else if (load_pixel) begin
        shape_q <= {shape_q[23:0], 1'b0};
        idx     <= idx + 5'd1;
        if (col == 3'd4) begin
          col <= 3'd0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

endmodule
